// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the execution sequencer.
package exec_seq_pkg;

  typedef enum logic [1:0] {
    S_STEP = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_REL  = 2'd3
  } state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  function automatic logic is_ebreak(input logic [31:0] inst);
    return inst == EBREAK_INST;
  endfunction

endpackage

// File: rtl/exec_sequencer_step_debounce.sv
// Step push-button conditioner: 2-FF synchronizer, stability debouncer and a
// one-cycle press pulse on the debounced 1->0 transition.
module step_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter tracks the run of samples disagreeing with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: issues the one-cycle cpu_en commit strobe in run, step
// and halt modes. Optional breakpoint support with EXEC_SEQ_BREAKPOINT_EN.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned DIV_MAX    = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock_reg,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic [31:0]      inst,
  input  logic [PC_W-1:0]  pc,
`ifdef EXEC_SEQ_BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr,
  output logic             bp_hit,
`endif
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned TickW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  state_e             state_q, state_d;
  logic               run_s1_q, run_s2_q, run_low_q;
  logic [TickW-1:0]   tick_q, tick_d;
  logic               cpu_en_q, cpu_en_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               btn_level, btn_press;
  logic               run_rise, tick, eb, bp_match;

  step_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_debounce (
    .clk_i  (clock_reg),
    .rst_ni (reset),
    .btn_i  (step_btn),
    .level_o(btn_level),
    .press_o(btn_press)
  );

  // run_low_q only arms after the switch is seen low, so a switch left high
  // through reset cannot enter run mode.
  assign run_rise = run_s2_q & run_low_q;
  assign tick     = (state_q == S_RUN) && (tick_q == TickW'(DIV_MAX - 1));
  assign eb       = is_ebreak(inst);

`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  assign bp_match = (pc == bp_addr);

  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) bp_hit_q <= 1'b0;
    else        bp_hit_q <= bp_hit_d;
  end

  always_comb begin
    bp_hit_d = bp_hit_q;
    if (state_q == S_STEP && run_rise) begin
      bp_hit_d = 1'b0;
    end else if (state_q == S_RUN && run_s2_q && tick && !eb && bp_match) begin
      bp_hit_d = 1'b1;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_match  = 1'b0;
`endif

  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) begin
      state_q   <= S_STEP;
      run_s1_q  <= 1'b1;
      run_s2_q  <= 1'b1;
      run_low_q <= 1'b0;
      tick_q    <= '0;
      cpu_en_q  <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_s1_q  <= run_sw;
      run_s2_q  <= run_s1_q;
      run_low_q <= ~run_s2_q;
      tick_q    <= tick_d;
      cpu_en_q  <= cpu_en_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_STEP: begin
        if (run_rise)       state_d = S_RUN;
        else if (btn_press) state_d = eb ? S_HALT : S_REL;
      end
      S_REL: begin
        if (btn_level) state_d = S_STEP;
      end
      S_RUN: begin
        if (!run_s2_q)     state_d = S_STEP;
        else if (tick) begin
          if (eb)            state_d = S_HALT;
          else if (bp_match) state_d = S_STEP;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_STEP;
    endcase
  end

  // Priority within a tick: switch low, then ebreak, then breakpoint, then commit.
  always_comb begin
    cpu_en_d = 1'b0;
    case (state_q)
      S_STEP:  cpu_en_d = !run_rise && btn_press && !eb;
      S_RUN:   cpu_en_d = run_s2_q && tick && !eb && !bp_match;
      default: cpu_en_d = 1'b0;
    endcase
    tick_d   = (state_q == S_RUN && state_d == S_RUN && !tick) ? tick_q + 1'b1 : '0;
    halted_d = (state_d == S_HALT);
    cnt_d    = cnt_q + CNT_W'(cpu_en_d);
  end

  assign cpu_en    = cpu_en_q;
  assign halted    = halted_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios plus random stimulus, all
// checked every cycle against a behavioural reference model.
module tb_exec_sequencer;

  localparam int unsigned DIV  = 4;
  localparam int unsigned DEB  = 3;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_sw;
  logic        step_btn;
  logic [31:0] inst;
  logic [7:0]  pc;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] instr_cnt;
`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic [7:0]  bp_addr;
  logic        bp_hit;
`endif

  exec_sequencer #(
    .DIV_MAX   (DIV),
    .DEB_CYCLES(DEB),
    .PC_W      (8),
    .CNT_W     (16)
  ) dut (
    .clock_reg(clk),
    .reset    (rst_n),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .inst     (inst),
    .pc       (pc),
`ifdef EXEC_SEQ_BREAKPOINT_EN
    .bp_addr  (bp_addr),
    .bp_hit   (bp_hit),
`endif
    .cpu_en   (cpu_en),
    .halted   (halted),
    .state    (state),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  bit pc_auto = 1'b0;

  // Reference model: modes 0 step, 1 run, 2 halt, 3 waiting for release.
  int          m_mode;
  int unsigned m_cnt;
  int unsigned m_run_age;
  bit          m_cpu_en, m_bp;
  bit          m_run_h1, m_run_h2, m_run_was_low;
  bit          m_btn_h1, m_btn_h2, m_level, m_press;
  int          m_streak;
  bit          s_run, s_btn, rise, ebreak, bpm;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_run_age = 0; m_cpu_en = 0; m_bp = 0;
      m_run_h1 = 1; m_run_h2 = 1; m_run_was_low = 0;
      m_btn_h1 = 1; m_btn_h2 = 1; m_level = 1; m_press = 0; m_streak = 0;
    end else begin
      s_run  = m_run_h2;
      s_btn  = m_btn_h2;
      rise   = s_run && m_run_was_low;
      ebreak = (inst == EBRK);
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bpm = (pc == bp_addr);
`else
      bpm = 1'b0;
`endif
      m_cpu_en = 0;
      case (m_mode)
        0: begin
          if (rise) begin
            m_mode = 1; m_run_age = 0; m_bp = 0;
          end else if (m_press) begin
            if (ebreak) m_mode = 2;
            else begin m_cpu_en = 1; m_mode = 3; end
          end
        end
        3: if (m_level) m_mode = 0;
        1: begin
          if (!s_run) m_mode = 0;
          else if (m_run_age % DIV == DIV - 1) begin
            if (ebreak)   m_mode = 2;
            else if (bpm) begin m_mode = 0; m_bp = 1; end
            else          m_cpu_en = 1;
          end
          m_run_age++;
        end
        default: ;
      endcase
      if (m_cpu_en) m_cnt = (m_cnt + 1) & 32'hFFFF;
      m_press = 0;
      if (s_btn == m_level) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == DEB) begin
          m_level = s_btn; m_press = !s_btn; m_streak = 0;
        end
      end
      m_run_was_low = !s_run;
      m_run_h2 = m_run_h1; m_run_h1 = run_sw;
      m_btn_h2 = m_btn_h1; m_btn_h1 = step_btn;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_n(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (cpu_en) pulses++;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, input string name);
    int k;
    k = 0;
    while (state !== s && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, state, s);
  endtask

  task automatic toggle_run();
    int p;
    run_sw = 1'b0;
    tick_n(5, p);
    run_sw = 1'b1;
  endtask

  task automatic press(input int hold, output int pulses, output int lat);
    pulses = 0;
    lat = -1;
    step_btn = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_en) pulses++;
    end
  endtask

  int p, p2, lat, lat2, got, k, last, r, hold;
  int gap[5];

  initial begin
    rst_n = 1'b0; run_sw = 1'b1; step_btn = 1'b1; inst = NOP; pc = 8'd0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
    bp_addr = 8'h0C;
`endif
    fork
      forever begin
        @(negedge clk);
        if (rst_n && chk_on) begin
          check("cpu_en", cpu_en, m_cpu_en);
          check("state", state, m_mode);
          check("halted", halted, m_mode == 2);
          check("instr_cnt", instr_cnt, m_cnt);
`ifdef EXEC_SEQ_BREAKPOINT_EN
          check("bp_hit", bp_hit, m_bp);
`endif
        end
        if (pc_auto && cpu_en) pc = pc + 8'd4;
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_en", cpu_en, 0);
    check("reset_state", state, 0);
    check("reset_halted", halted, 0);
    check("reset_instr_cnt", instr_cnt, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Switch high through reset must not start run mode.
    tick_n(50, p);
    check("runsw_held_pulses", p, 0);
    check("runsw_held_state", state, 0);
    check("runsw_held_cnt", instr_cnt, 0);

    toggle_run();
    wait_state(2'd1, 10, "run_entry_state");
    got = 0; k = 0; last = 0;
    while (got < 5 && k < 40) begin
      @(negedge clk);
      k++;
      if (cpu_en) begin
        gap[got] = k - last;
        last = k;
        got++;
      end
    end
    check("run_pulses", got, 5);
    for (int i = 0; i < 5; i++) check("run_gap", gap[i], DIV);
    check("run_instr_cnt", instr_cnt, 5);

    // Switch low arrives at the FSM on the same edge as the next tick.
    @(negedge clk);
    run_sw = 1'b0;
    tick_n(8, p);
    check("runsw_vs_tick_pulses", p, 0);
    check("runsw_vs_tick_state", state, 0);
    check("runsw_vs_tick_cnt", instr_cnt, 5);

    press(20, p, lat);
    press(20, p2, lat2);
    check("step_pulses", p + p2, 2);
    tests++;
    if (lat < 5 || lat > 7) begin
      fails++;
      $display("FAIL step_latency: got %0d, expected 6 (+/-1)", lat);
    end
    check("step_instr_cnt", instr_cnt, 7);
    press(2, p, lat);
    check("glitch_pulses", p, 0);

    run_sw = 1'b1;
    wait_state(2'd1, 10, "ebreak_run_state");
    k = 0;
    while (!cpu_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("ebreak_pre_pulse", cpu_en, 1);
    inst = EBRK;
    tick_n(12, p);
    check("ebreak_pulses", p, 0);
    check("ebreak_halted", halted, 1);
    check("ebreak_state", state, 2);
    press(20, p, lat);
    check("halt_step_pulses", p, 0);
    toggle_run();
    tick_n(8, p);
    check("halt_run_state", state, 2);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_halted", halted, 0);
    check("async_rst_state", state, 0);
    check("async_rst_cnt", instr_cnt, 0);
    check("async_rst_cpu_en", cpu_en, 0);
    inst = NOP;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EXEC_SEQ_BREAKPOINT_EN
    pc = 8'd0;
    pc_auto = 1'b1;
    toggle_run();
    wait_state(2'd1, 10, "bp_run_state");
    tick_n(30, p);
    check("bp_pulses", p, 3);
    check("bp_hit_set", bp_hit, 1);
    check("bp_state", state, 0);
    press(20, p, lat);
    check("bp_step_pulses", p, 1);
    toggle_run();
    wait_state(2'd1, 10, "bp_rerun_state");
    check("bp_hit_clear", bp_hit, 0);
    run_sw = 1'b0;
    tick_n(6, p);
`endif

    pc_auto = 1'b1;
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else if (r < 35) begin
        run_sw = ~run_sw;
      end else if (r < 70) begin
        step_btn = ~step_btn;
      end else if (r < 90) begin
        inst = ($urandom_range(0, 24) == 0) ? EBRK : $urandom;
      end else begin
`ifdef EXEC_SEQ_BREAKPOINT_EN
        bp_addr = 8'($urandom_range(0, 15) * 4);
`endif
        inst = NOP;
      end
      hold = $urandom_range(1, 12);
      tick_n(hold, p);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
